// File: rtl/gpsdo_pkg.sv
// Shared types and default constants for the GPS-disciplined 1PPS blocks.
package gpsdo_pkg;

    typedef enum logic [1:0] {
        FREE,
        ARMED,
        LOCKED
    } pps_state_t;

    localparam int CLK_HZ_DEF      = 10000000;
    localparam int PULSE_DEF       = 1000000;
    localparam int GPS_TIMEOUT_DEF = 15000000;
    localparam int MIN_GAP_DEF     = 5000000;

endpackage

// File: rtl/pps_local_gen_if.sv
// 1PPS generator pins: raw GPS and realign request in, local pulse and status out.
interface pps_local_gen_if;
    import gpsdo_pkg::*;

    logic        _1PPS_GPS;
    logic        DIV_RESET;
    logic        _1PPS_Local;
    logic        ALIGNED;
    logic        GPS_VALID;
    logic [31:0] SEC_CNT;
    logic [15:0] ALIGN_CNT;

    modport master (
        input  _1PPS_GPS,
        input  DIV_RESET,
        output _1PPS_Local,
        output ALIGNED,
        output GPS_VALID,
        output SEC_CNT,
        output ALIGN_CNT
    );

    modport slave (
        output _1PPS_GPS,
        output DIV_RESET,
        input  _1PPS_Local,
        input  ALIGNED,
        input  GPS_VALID,
        input  SEC_CNT,
        input  ALIGN_CNT
    );

endinterface

// File: rtl/pps_edge_sync.sv
// Synchronizes an asynchronous pulse and flags its rising edge; rise_out is combinational
// off the last sync flop, SYNC_STAGES cycles after the pin; no backpressure.
module pps_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic CLK_SYS,
    input  logic CLK_RST,
    input  logic async_in,
    output logic rise_out
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   dly_q;

    always_ff @(posedge CLK_SYS) begin
        if (CLK_RST) begin
            sync_q <= '0;
            dly_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
            dly_q  <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise_out = sync_q[SYNC_STAGES-1] & ~dly_q;

endmodule

// File: rtl/pps_local_gen.sv
// Local 1PPS divider snapped to qualified GPS edges, with GPS presence/holdover tracking.
// Pin-to-pulse latency SYNC_STAGES+1 cycles; no backpressure, DIV_RESET is a level request.
module pps_local_gen
    import gpsdo_pkg::*;
#(
    parameter int CLK_HZ       = CLK_HZ_DEF,
    parameter int PULSE_CYCLES = PULSE_DEF,
    parameter int SYNC_STAGES  = 2,
    parameter int GPS_TIMEOUT  = GPS_TIMEOUT_DEF,
    parameter int MIN_GAP      = MIN_GAP_DEF
) (
    input  logic            CLK_SYS,
    input  logic            CLK_RST,
    pps_local_gen_if.master pps
);

    localparam int DW = $clog2(CLK_HZ);
    localparam int GW = $clog2(GPS_TIMEOUT + 1);

    localparam logic [DW-1:0] DIV_MAX   = DW'(CLK_HZ - 1);
    localparam logic [DW-1:0] PULSE_LIM = DW'(PULSE_CYCLES);
    localparam logic [GW-1:0] GAP_MAX   = GW'(GPS_TIMEOUT);
    localparam logic [GW-1:0] GAP_TRIP  = GW'(GPS_TIMEOUT - 1);
    localparam logic [GW-1:0] GAP_MIN   = GW'(MIN_GAP);

    pps_state_t    state;
    pps_state_t    state_nxt;
    logic [DW-1:0] div_cnt;
    logic [DW-1:0] div_nxt;
    logic [GW-1:0] gap_cnt;
    logic [GW-1:0] gap_nxt;
    logic          gps_rise;
    logic          timeout;
    logic          gps_q;
    logic          align;
    logic          sec_tick;
    logic          gps_seen;
    logic          gps_valid;
    logic          pps_q;
    logic [31:0]   sec_cnt;
    logic [15:0]   align_cnt;

    pps_edge_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_edge_sync (
        .CLK_SYS  (CLK_SYS),
        .CLK_RST  (CLK_RST),
        .async_in (pps._1PPS_GPS),
        .rise_out (gps_rise)
    );

    // Timeout fires once, on the cycle gap_cnt steps onto GPS_TIMEOUT, and
    // outranks a coincident GPS edge.
    always_comb begin
        timeout = (gap_cnt == GAP_TRIP);
        gps_q   = gps_rise & (~gps_seen | (gap_cnt >= GAP_MIN)) & ~timeout;
        gap_nxt = gap_cnt;
        if (gps_q) begin
            gap_nxt = '0;
        end else if (gap_cnt != GAP_MAX) begin
            gap_nxt = gap_cnt + GW'(1);
        end
    end

    always_comb begin
        state_nxt = state;
        align     = 1'b0;
        if (timeout) begin
            state_nxt = FREE;
        end else begin
            case (state)
                ARMED: begin
                    if (gps_q) begin
                        align     = 1'b1;
                        state_nxt = LOCKED;
                    end
                end
                LOCKED: begin
                    if (pps.DIV_RESET && gps_q) begin
                        align = 1'b1;
                    end else if (pps.DIV_RESET) begin
                        state_nxt = ARMED;
                    end
                end
                FREE: begin
                    if (gps_q) begin
                        align     = 1'b1;
                        state_nxt = LOCKED;
                    end else if (pps.DIV_RESET) begin
                        state_nxt = ARMED;
                    end
                end
                default: state_nxt = ARMED;
            endcase
        end
    end

    // A second boundary is any step onto phase 0, whether by wrap or by align.
    always_comb begin
        div_nxt = '0;
        if (!align && (div_cnt != DIV_MAX)) begin
            div_nxt = div_cnt + DW'(1);
        end
        sec_tick = (div_nxt == '0) && (div_cnt != '0);
    end

    always_ff @(posedge CLK_SYS) begin
        if (CLK_RST) begin
            state <= ARMED;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge CLK_SYS) begin
        if (CLK_RST) begin
            div_cnt   <= '0;
            gap_cnt   <= '0;
            gps_seen  <= 1'b0;
            gps_valid <= 1'b0;
            pps_q     <= 1'b0;
            sec_cnt   <= '0;
            align_cnt <= '0;
        end else begin
            div_cnt <= div_nxt;
            gap_cnt <= gap_nxt;
            pps_q   <= (div_nxt < PULSE_LIM);
            if (timeout) begin
                gps_seen  <= 1'b0;
                gps_valid <= 1'b0;
            end else if (gps_q) begin
                gps_seen  <= 1'b1;
                gps_valid <= 1'b1;
            end
            if (sec_tick) begin
                sec_cnt <= sec_cnt + 32'd1;
            end
            if (align && (align_cnt != 16'hFFFF)) begin
                align_cnt <= align_cnt + 16'd1;
            end
        end
    end

    assign pps._1PPS_Local = pps_q;
    assign pps.ALIGNED     = (state == LOCKED);
    assign pps.GPS_VALID   = gps_valid;
    assign pps.SEC_CNT     = sec_cnt;
    assign pps.ALIGN_CNT   = align_cnt;

endmodule

// File: tb/tb_pps_local_gen.sv
// Directed scenarios plus randomized GPS/DIV_RESET/reset traffic against a cycle-count model.
module tb_pps_local_gen;
    import gpsdo_pkg::*;

    localparam int HZ    = 1000;
    localparam int PULSE = 100;
    localparam int SS    = 2;
    localparam int TO    = 1500;
    localparam int MING  = 500;
    localparam int NL    = 44;

    logic clk;
    logic rst;

    pps_local_gen_if bus ();

    pps_local_gen #(
        .CLK_HZ       (HZ),
        .PULSE_CYCLES (PULSE),
        .SYNC_STAGES  (SS),
        .GPS_TIMEOUT  (TO),
        .MIN_GAP      (MING)
    ) dut (
        .CLK_SYS (clk),
        .CLK_RST (rst),
        .pps     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model: divider phase = cycles since last zero-epoch mod HZ; gap = cycles since last reference.
    int          cyc = 0;
    int          epoch;
    int          last_ref;
    bit          seen;
    bit          valid;
    pps_state_t  st;
    logic [31:0] m_sec;
    int          m_acnt;
    bit          m_loc;
    bit          pin_hist [0:SS];

    int n_vec = 0;
    int n_err = 0;

    // fld: 0 local, 1 aligned, 2 gps_valid, 3 sec, 4 align_cnt
    int lit_cyc [NL] = '{202, 203, 203, 203, 203, 203, 302, 303, 1203, 1203,
                         3702, 4209, 4209, 4210, 4210, 4210, 4309, 4310, 5510, 5510,
                         6214, 6215, 6215, 6215, 7222, 7222, 7223, 7223, 7223, 8722,
                         8722, 8723, 8723, 9222, 9223, 9274, 9274, 9274, 9274, 9602,
                         9603, 9603, 9603, 9603};
    int lit_fld [NL] = '{0, 0, 1, 2, 3, 4, 0, 0, 3, 0,
                         1, 1, 3, 1, 4, 3, 0, 0, 1, 4,
                         1, 1, 4, 3, 1, 4, 1, 4, 3, 2,
                         1, 2, 1, 0, 0, 0, 3, 4, 2, 0,
                         0, 1, 4, 3};
    int lit_val [NL] = '{0, 1, 1, 1, 1, 1, 1, 0, 2, 1,
                         0, 0, 5, 1, 2, 6, 1, 0, 0, 2,
                         0, 1, 3, 9, 1, 3, 1, 4, 11, 1,
                         1, 0, 0, 0, 1, 0, 0, 0, 0, 0,
                         1, 1, 1, 1};

    task automatic model_edge();
        int gap;
        int old_ph;
        int new_ph;
        bit rise;
        bit to_ev;
        bit q;
        bit al;
        cyc++;
        if (rst) begin
            epoch    = cyc;
            last_ref = cyc;
            seen     = 1'b0;
            valid    = 1'b0;
            st       = ARMED;
            m_sec    = '0;
            m_acnt   = 0;
            m_loc    = 1'b0;
            for (int i = 0; i <= SS; i++) pin_hist[i] = 1'b0;
            return;
        end
        rise  = pin_hist[SS-1] && !pin_hist[SS];
        gap   = cyc - 1 - last_ref;
        if (gap > TO) gap = TO;
        to_ev = (gap == TO - 1);
        q     = rise && (!seen || gap >= MING) && !to_ev;
        al    = 1'b0;
        if (to_ev) begin
            st    = FREE;
            seen  = 1'b0;
            valid = 1'b0;
        end else if (q) begin
            seen     = 1'b1;
            valid    = 1'b1;
            last_ref = cyc;
            if (st != LOCKED || bus.DIV_RESET) begin
                al = 1'b1;
                st = LOCKED;
            end
        end else if (bus.DIV_RESET) begin
            st = ARMED;
        end
        old_ph = (cyc - 1 - epoch) % HZ;
        if (al) epoch = cyc;
        new_ph = (cyc - epoch) % HZ;
        if (new_ph == 0 && old_ph != 0) m_sec = m_sec + 32'd1;
        if (al && m_acnt < 65535) m_acnt++;
        m_loc = (new_ph < PULSE);
        for (int i = SS; i > 0; i--) pin_hist[i] = pin_hist[i-1];
        pin_hist[0] = bus._1PPS_GPS;
    endtask

    function automatic int dut_field(int fld);
        case (fld)
            0:       return int'(bus._1PPS_Local);
            1:       return int'(bus.ALIGNED);
            2:       return int'(bus.GPS_VALID);
            3:       return int'(bus.SEC_CNT);
            default: return int'(bus.ALIGN_CNT);
        endcase
    endfunction

    // Model step on each rising edge, checks on the following falling edge.
    initial begin
        forever begin
            @(posedge clk);
            model_edge();
            @(negedge clk);
            n_vec++;
            if (bus._1PPS_Local !== m_loc || bus.ALIGNED !== (st == LOCKED) ||
                bus.GPS_VALID !== valid || bus.SEC_CNT !== m_sec ||
                bus.ALIGN_CNT !== 16'(m_acnt)) begin
                n_err++;
                $display("FAIL model cyc%0d: got loc=%b aln=%b vld=%b sec=%0d acnt=%0d, want loc=%b aln=%b vld=%b sec=%0d acnt=%0d",
                         cyc, bus._1PPS_Local, bus.ALIGNED, bus.GPS_VALID, bus.SEC_CNT, bus.ALIGN_CNT,
                         m_loc, (st == LOCKED), valid, m_sec, m_acnt);
            end
            for (int i = 0; i < NL; i++) begin
                if (lit_cyc[i] == cyc) begin
                    n_vec++;
                    if (dut_field(lit_fld[i]) != lit_val[i]) begin
                        n_err++;
                        $display("FAIL literal%0d cyc%0d field%0d: got %0d want %0d",
                                 i, cyc, lit_fld[i], dut_field(lit_fld[i]), lit_val[i]);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic goto(input int c);
        while (cyc < c) step();
    endtask

    task automatic gps_at(input int c, input int width);
        goto(c);
        bus._1PPS_GPS = 1'b1;
        goto(c + width);
        bus._1PPS_GPS = 1'b0;
    endtask

    task automatic dr_at(input int c);
        goto(c);
        bus.DIV_RESET = 1'b1;
        goto(c + 1);
        bus.DIV_RESET = 1'b0;
    endtask

    int gps_hi;
    int dr_hi;
    int next_gps;

    initial begin
        rst           = 1'b1;
        bus._1PPS_GPS = 1'b0;
        bus.DIV_RESET = 1'b0;
        goto(4);
        rst = 1'b0;

        // Lock on first edge, then steady 1 s GPS.
        gps_at(200, 50);
        gps_at(1200, 50);
        gps_at(2200, 50);
        gps_at(3200, 50);
        // Realign request, GPS shifted +7.
        dr_at(3700);
        gps_at(4207, 50);
        // Edge while locked, re-arm, glitch 300 after, then shifted edge aligns.
        gps_at(5207, 50);
        dr_at(5400);
        gps_at(5507, 3);
        gps_at(6212, 50);
        // DIV_RESET coincident with a qualified edge while locked.
        goto(7220);
        bus._1PPS_GPS = 1'b1;
        goto(7222);
        bus.DIV_RESET = 1'b1;
        goto(7223);
        bus.DIV_RESET = 1'b0;
        goto(7270);
        bus._1PPS_GPS = 1'b0;
        // GPS lost; holdover, then reset mid-pulse and relock.
        goto(9273);
        rst = 1'b1;
        goto(9274);
        rst = 1'b0;
        gps_at(9600, 50);

        gps_hi   = 0;
        dr_hi    = 0;
        next_gps = cyc + 300;
        repeat (22000) begin
            if (cyc >= next_gps) begin
                gps_hi   = $urandom_range(60, 2);
                next_gps = cyc + 990 + $urandom_range(20, 0);
                if ($urandom_range(7, 0) == 0) next_gps += 1000 * $urandom_range(2, 1);
            end else if (gps_hi == 0 && $urandom_range(299, 0) == 0) begin
                gps_hi = $urandom_range(3, 1);
            end
            if (dr_hi == 0 && $urandom_range(499, 0) == 0) dr_hi = $urandom_range(3, 1);
            bus._1PPS_GPS = (gps_hi > 0);
            bus.DIV_RESET = (dr_hi > 0);
            rst           = ($urandom_range(5999, 0) == 0);
            if (gps_hi > 0) gps_hi--;
            if (dr_hi > 0) dr_hi--;
            step();
        end
        rst           = 1'b0;
        bus._1PPS_GPS = 1'b0;
        bus.DIV_RESET = 1'b0;
        step();
        step();
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
